// File: rtl/dmux_stream_router.sv
// Registered 1-to-NUM_CH word demux, one cycle in-to-out; a full, stalled lane only holds off words for itself.
// Define DMUX_STREAM_CNT_EN to add per-lane output transfer counters (cnt, cnt_clr).
module dmux_stream_router #(
  parameter int N      = 84,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
`ifdef DMUX_STREAM_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*N-1:0]      out_data,
`ifdef DMUX_STREAM_CNT_EN
  output logic [NUM_CH*CNT_W-1:0]  cnt,
  input  logic                     cnt_clr,
`endif
  output logic                     sel_err,
  input  logic                     clr_err
);

  localparam logic [SEL_W:0] NUM_CH_X = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0]        vld;
  logic [NUM_CH-1:0]        acc;
  logic [NUM_CH-1:0]        drain;
  logic [NUM_CH-1:0]        load;
  logic [NUM_CH-1:0][N-1:0] dat;
  logic                     legal;

  assign legal = {1'b0, in_sel} < NUM_CH_X;
  assign acc   = ~vld | out_ready;
  assign drain = vld & out_ready;

  // Out-of-range selects are always accepted so a bad word can never wedge the input.
  always_comb begin
    in_ready = 1'b1;
    load     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_sel == SEL_W'(c)) begin
        in_ready = acc[c];
        load[c]  = in_valid && acc[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      dat <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (load[c]) begin
          vld[c] <= 1'b1;
          dat[c] <= in_data;
        end else if (drain[c]) begin
          vld[c] <= 1'b0;
          dat[c] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (in_valid && !legal) begin
      sel_err <= 1'b1;
    end else if (clr_err) begin
      sel_err <= 1'b0;
    end
  end

  assign out_valid = vld;
  assign out_data  = dat;

`ifdef DMUX_STREAM_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

  // Clear dominates a coincident transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (drain[c]) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
      end
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dmux_stream_router.sv
// Bench for dmux_stream_router: queue-based reference model on a 4-lane instance,
// directed illegal-select checks on a 3-lane instance.
module tb_dmux_stream_router;
  localparam int N   = 84;
  localparam int NC  = 4;
  localparam int BN  = 16;
  localparam int BNC = 3;
`ifdef DMUX_STREAM_CNT_EN
  localparam int CW  = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid, in_ready;
  logic [N-1:0]    in_data;
  logic [1:0]      in_sel;
  logic [NC-1:0]   out_valid, out_ready;
  logic [NC*N-1:0] out_data;
  logic            sel_err, clr_err;

  logic             b_in_valid, b_in_ready;
  logic [BN-1:0]    b_in_data;
  logic [1:0]       b_in_sel;
  logic [BNC-1:0]   b_out_valid, b_out_ready;
  logic [BNC*BN-1:0] b_out_data;
  logic             b_sel_err, b_clr_err;

`ifdef DMUX_STREAM_CNT_EN
  logic [NC*CW-1:0]  cnt;
  logic              cnt_clr;
  logic [BNC*CW-1:0] b_cnt;
  logic              b_cnt_clr;
  int                mcnt[NC];
`endif

  dmux_stream_router #(
    .N(N), .NUM_CH(NC)
`ifdef DMUX_STREAM_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef DMUX_STREAM_CNT_EN
    .cnt(cnt), .cnt_clr(cnt_clr),
`endif
    .sel_err(sel_err), .clr_err(clr_err)
  );

  dmux_stream_router #(
    .N(BN), .NUM_CH(BNC)
`ifdef DMUX_STREAM_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
`ifdef DMUX_STREAM_CNT_EN
    .cnt(b_cnt), .cnt_clr(b_cnt_clr),
`endif
    .sel_err(b_sel_err), .clr_err(b_clr_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit [N-1:0] q[NC][$];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock of the 4-lane instance: compare against the model, then advance the model.
  task automatic cyc(input string tag, output bit took);
    logic [NC-1:0]   ev;
    logic [NC*N-1:0] ed;
    logic            eir;
    bit              pop;
    int              s;
`ifdef DMUX_STREAM_CNT_EN
    logic [NC*CW-1:0] ec;
`endif
    #1;
    ev = '0;
    ed = '0;
    s  = int'(in_sel);
    for (int c = 0; c < NC; c++) begin
      if (q[c].size() > 0) begin
        ev[c] = 1'b1;
        ed[c*N +: N] = q[c][0];
      end
    end
    eir = (q[s].size() == 0) || out_ready[s];
    chk({tag, " in_ready"}, in_ready, eir);
    chk({tag, " out_valid"}, out_valid, ev);
    chk({tag, " out_data"}, out_data, ed);
    chk({tag, " sel_err"}, sel_err, 1'b0);
`ifdef DMUX_STREAM_CNT_EN
    for (int c = 0; c < NC; c++) ec[c*CW +: CW] = CW'(mcnt[c]);
    chk({tag, " cnt"}, cnt, ec);
`endif
    took = in_valid && eir;
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      pop = (q[c].size() > 0) && out_ready[c];
      if (pop) q[c].delete(0);
`ifdef DMUX_STREAM_CNT_EN
      if (cnt_clr) mcnt[c] = 0;
      else if (pop) mcnt[c] = (mcnt[c] + 1) % (1 << CW);
`endif
    end
    if (took) q[s].push_back(in_data);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      q[c].delete();
`ifdef DMUX_STREAM_CNT_EN
      mcnt[c] = 0;
`endif
    end
  endtask

  initial begin
    bit took, held;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0; clr_err = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = '0; b_clr_err = 1'b0;
`ifdef DMUX_STREAM_CNT_EN
    cnt_clr = 1'b0; b_cnt_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, '0);
    chk("rst out_data", out_data, '0);
    chk("rst sel_err", sel_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NC; k++) begin
      in_sel = 2'(k);
      #1 chk("idle in_ready", in_ready, 1'b1);
    end
    chk("idle out_valid", out_valid, '0);

    // single steer, blocked second word, other lane still accepted
    in_valid = 1'b1; in_sel = 2'd2; in_data = 84'h123; out_ready = '0;
    cyc("steer", took);
    chk("steer vld", out_valid, 4'b0100);
    chk("steer dat2", out_data[2*N +: N], 84'h123);
    in_data = 84'h456;
    #1 chk("steer full", in_ready, 1'b0);
    cyc("steer blk", took);
    in_sel = 2'd1; in_data = 84'h789;
    cyc("steer ch1", took);
    chk("steer vld2", out_valid, 4'b0110);
    in_valid = 1'b0; out_ready = '1;
    cyc("drain", took);

    // back-to-back on lane 0
    out_ready = 4'b0001; in_valid = 1'b1; in_sel = 2'd0;
    for (int i = 1; i <= 8; i++) begin
      in_data = N'(i);
      cyc("b2b", took);
      chk("b2b data", out_data[0 +: N], N'(i));
      chk("b2b vld", out_valid[0], 1'b1);
    end
    in_valid = 1'b0;
    cyc("b2b end", took);

    // random traffic, inputs held while stalled
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = N'({$urandom, $urandom, $urandom});
      end
      out_ready = 4'($urandom);
      cyc("rnd", took);
      held = in_valid && !took;
    end
    in_valid = 1'b0; out_ready = '1;
    cyc("rnd end", took);

    // asynchronous reset with lanes 0 and 3 full
    out_ready = '0; in_valid = 1'b1; in_sel = 2'd0; in_data = 84'hAAA;
    cyc("fill0", took);
    in_sel = 2'd3; in_data = 84'hBBB;
    cyc("fill3", took);
    in_valid = 1'b0;
    chk("fill vld", out_valid, 4'b1001);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", out_valid, '0);
    chk("arst out_data", out_data, '0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef DMUX_STREAM_CNT_EN
    out_ready = 4'b0010; in_valid = 1'b1; in_sel = 2'd1;
    for (int i = 0; i < 17; i++) begin
      in_data = N'(i + 100);
      cyc("cnt fill", took);
    end
    in_valid = 1'b0;
    cyc("cnt last", took);
    chk("cnt wrap", cnt[1*CW +: CW], 4'd1);
    in_valid = 1'b1; in_data = 84'h5;
    cyc("cnt load", took);
    in_valid = 1'b0; cnt_clr = 1'b1;
    cyc("cnt clr", took);
    cnt_clr = 1'b0;
    chk("cnt clr wins", cnt[1*CW +: CW], 4'd0);
`endif

    // illegal select on the 3-lane instance
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 16'hBEEF; b_out_ready = '0;
    #1 chk("ill in_ready", b_in_ready, 1'b1);
    @(posedge clk); #1;
    chk("ill out_valid", b_out_valid, 3'b000);
    chk("ill sel_err", b_sel_err, 1'b1);
    b_clr_err = 1'b1;
    @(posedge clk); #1;
    chk("ill set wins", b_sel_err, 1'b1);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ill clr", b_sel_err, 1'b0);
    b_clr_err = 1'b0;
    b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 16'h0055;
    #1 chk("b legal rdy", b_in_ready, 1'b1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("b legal vld", b_out_valid, 3'b100);
    chk("b legal dat", b_out_data, {16'h0055, 32'h0});
    chk("b no err", b_sel_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
